ex_stage_exmem: RTL and testbench
=================================

// Module: ex_stage_exmem
// PURPOSE
// - Execute stage directly downstream of the ID/EX pipeline register.
// - Forwards operands from MEM/WB, runs the ALU, holds the C/Z flag registers and registers
//   the result plus control into the EX/MEM pipeline register (PR3_*).
// - Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
// - WORD_LEN         8   datapath width; shift counts are taken modulo WORD_LEN
// - INSTRUCTION_LEN  19  instruction width
// PORTS
// - clk                     in   1    clock, rising edge
// - rst                     in   1    asynchronous, active-low reset
// - PR2_instruction         in   19   rd=[13:11], rs1=[10:8], imm8=[7:0], shamt=[2:0]
// - PR2_RF_out1/out2        in   8    register-file operands
// - PR2_RF_r2               in   3    rs2 index
// - PR2_ALU_op              in   4    alu_op_e
// - PR2_sel_ALU_src_reg2/const/shift_count   in 1 each   B-operand select, one-hot
// - PR2_sel_Cin_alu         in   1    ADDC/SUBC use the C flag as carry-in
// - PR2_MEM_write/MEM_read/sel_RF_write_src_ALU/sel_RF_write_src_MEM/RF_write_en   in 1 each
// - fwd_mem_en, fwd_mem_rd, fwd_mem_data   in 1/3/8   MEM-stage writeback candidate
// - fwd_wb_en, fwd_wb_rd, fwd_wb_data      in 1/3/8   WB-stage writeback candidate
// - stall                   in   1    hold PR3_* and flags
// - flush                   in   1    load a bubble into PR3_*
// - PR3_alu_result          out  8    registered ALU result
// - PR3_store_data          out  8    registered forwarded rs2 value (memory write data)
// - PR3_rd                  out  3    registered destination index
// - PR3_MEM_write/MEM_read/sel_RF_write_src_ALU/sel_RF_write_src_MEM/RF_write_en   out 1 each
// - PR3_valid               out  1    0 = bubble
// - flag_C, flag_Z          out  1    current flag registers
// BEHAVIOUR
// - Reset (rst=0, async): every PR3_* output is 0, flag_C=0, flag_Z=0.
// - Latency: 1 clk from PR2_* to PR3_*. The forwarding/ALU path is combinational.
// - Forwarding, per operand (rs1 from the instruction, rs2 from PR2_RF_r2):
//   - MEM match (fwd_mem_en && rd==idx) wins over WB match; else use PR2_RF_out.
//   - Index 0 is forwarded like any other register (R0 is not hardwired).
// - B operand select, by priority: const -> zero-extended imm8; shift_count -> shamt;
//   reg2 -> forwarded rs2; none set -> 0.
// - ALU ops:
//   - 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 MASK (A&~B),
//     8 SHL, 9 SHR, 10 ROL, 11 ROR; 12-15 pass B.
//   - Arithmetic is WORD_LEN+1 bits wide; Cin = flag_C only when sel_Cin_alu && op is ADDC/SUBC.
//   - SUB/SUBC compute A-B-Cin; C = borrow.
//   - Shifts: amount = B mod WORD_LEN. C = last bit shifted out.
//     Amount 0 leaves C unchanged and result = A.
//   - Logic ops: C unchanged.
//   - Ops 0-11 update Z (result==0); ops 12-15 leave C and Z unchanged.
// - Clock edge, priority flush > stall > advance:
//   - flush: PR3_valid, PR3_RF_write_en, PR3_MEM_write and PR3_MEM_read all go to 0;
//     other PR3 fields don't-care (implemented as 0); flags hold.
//   - stall: all PR3_* and flags hold.
//   - advance: PR3_* <= computed values; PR3_valid <= 1.
//     Flags update only when PR2 carries a real op (PR2_RF_write_en | PR2_MEM_write | PR2_MEM_read).
// - Flush and stall asserted together: flush wins.
// - Reset mid-stall: reset wins immediately; the pipeline restarts empty.
// STRUCTURE
// - cpu_pkg holds: alu_op_e enum, instruction field LSB/MSB constants, WORD_LEN/INSTRUCTION_LEN defaults.
// - Sub-module alu_core: combinational; (a, b, op, cin, c_in_flag) -> (result, c_out, c_upd, z_upd).
// - Forwarding muxes, flag registers and the PR3 register live in this module.
// TESTING
// - Reset: drive rst=0 mid-run -> all PR3_* =0 and C=Z=0 asynchronously, before the next edge.
// - ADD 0xF0+0x20 (reg2) -> next cycle PR3_alu_result=0x10, C=1, Z=0.
//   Then ADDC 0x01+0x01 with sel_Cin_alu -> 0x03.
// - Forwarding: rs1=3, fwd_mem(3,0x55) and fwd_wb(3,0xAA) both active
//   -> MEM value wins, AND with imm 0x0F gives 0x05; with MEM disabled gives 0x0A.
// - Shifts: SHR 0x81 by shamt 1 -> 0x40, C=1. ROL 0x81 by 9 -> 0x03.
//   SHL by 0 -> result=A, C unchanged.
// - Stall for 3 cycles while PR2 changes -> PR3 and flags frozen. Flush+stall same cycle
//   -> PR3_valid=0, RF_write_en=0, MEM_write=0.
// - SUB 0x05-0x05 -> result 0, Z=1, C=0. A bubble (all enables 0) then leaves Z=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and field positions for the CPU pipeline stages.
package cpu_pkg;

   localparam int WORD_LEN_DEF        = 8;
   localparam int INSTRUCTION_LEN_DEF = 19;

   localparam int RD_MSB    = 13;
   localparam int RD_LSB    = 11;
   localparam int RS1_MSB   = 10;
   localparam int RS1_LSB   = 8;
   localparam int IMM_MSB   = 7;
   localparam int IMM_LSB   = 0;
   localparam int SHAMT_MSB = 2;
   localparam int SHAMT_LSB = 0;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDC = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SUBC = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_MASK = 4'd7,
      ALU_SHL  = 4'd8,
      ALU_SHR  = 4'd9,
      ALU_ROL  = 4'd10,
      ALU_ROR  = 4'd11
   } alu_op_e;

   typedef struct packed {
      logic mem_write;
      logic mem_read;
      logic src_alu;
      logic src_mem;
      logic rf_we;
   } pr3_ctrl_t;

   function automatic logic is_carry_op(input alu_op_e op);
      return (op == ALU_ADDC) || (op == ALU_SUBC);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry value and per-flag update strobes.
module alu_core
   import cpu_pkg::*;
#(
   parameter int WORD_LEN = WORD_LEN_DEF
) (
   input  logic [WORD_LEN-1:0] a,
   input  logic [WORD_LEN-1:0] b,
   input  alu_op_e             op,
   input  logic                cin,
   input  logic                c_in_flag,
   output logic [WORD_LEN-1:0] result,
   output logic                c_out,
   output logic                c_upd,
   output logic                z_upd
);

   localparam int SW = $clog2(WORD_LEN);

   logic [SW-1:0]   sh;
   logic [WORD_LEN:0] wide;

   always_comb begin
      sh     = SW'(b % WORD_LEN);
      wide   = '0;
      result = '0;
      c_out  = c_in_flag;
      c_upd  = 1'b0;
      z_upd  = 1'b1;
      case (op)
         ALU_ADD, ALU_ADDC: begin
            wide   = {1'b0, a} + {1'b0, b} + {{WORD_LEN{1'b0}}, cin};
            result = wide[WORD_LEN-1:0];
            c_out  = wide[WORD_LEN];
            c_upd  = 1'b1;
         end
         ALU_SUB, ALU_SUBC: begin
            // the wrap into the extra MSB is the borrow
            wide   = {1'b0, a} - {1'b0, b} - {{WORD_LEN{1'b0}}, cin};
            result = wide[WORD_LEN-1:0];
            c_out  = wide[WORD_LEN];
            c_upd  = 1'b1;
         end
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_MASK: result = a & ~b;
         ALU_SHL: begin
            wide   = {1'b0, a} << sh;
            result = wide[WORD_LEN-1:0];
            c_upd  = (sh != '0);
            if (c_upd) c_out = wide[WORD_LEN];
         end
         ALU_SHR: begin
            wide   = {a, 1'b0} >> sh;
            result = wide[WORD_LEN:1];
            c_upd  = (sh != '0);
            if (c_upd) c_out = wide[0];
         end
         ALU_ROL: begin
            result = (a << sh) | (a >> (WORD_LEN - int'(sh)));
            c_upd  = (sh != '0);
            if (c_upd) c_out = result[0];
         end
         ALU_ROR: begin
            result = (a >> sh) | (a << (WORD_LEN - int'(sh)));
            c_upd  = (sh != '0);
            if (c_upd) c_out = result[WORD_LEN-1];
         end
         default: begin
            result = b;
            z_upd  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_stage_exmem.sv
// Execute stage: operand forwarding, ALU, C/Z flags and the EX/MEM pipeline register.
module ex_stage_exmem
   import cpu_pkg::*;
#(
   parameter int WORD_LEN        = WORD_LEN_DEF,
   parameter int INSTRUCTION_LEN = INSTRUCTION_LEN_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [INSTRUCTION_LEN-1:0] PR2_instruction,
   input  logic [WORD_LEN-1:0]        PR2_RF_out1,
   input  logic [WORD_LEN-1:0]        PR2_RF_out2,
   input  logic [2:0]                 PR2_RF_r2,
   input  logic [3:0]                 PR2_ALU_op,
   input  logic                       PR2_sel_ALU_src_reg2,
   input  logic                       PR2_sel_ALU_src_const,
   input  logic                       PR2_sel_ALU_src_shift_count,
   input  logic                       PR2_sel_Cin_alu,
   input  logic                       PR2_MEM_write,
   input  logic                       PR2_MEM_read,
   input  logic                       PR2_sel_RF_write_src_ALU,
   input  logic                       PR2_sel_RF_write_src_MEM,
   input  logic                       PR2_RF_write_en,
   input  logic                       fwd_mem_en,
   input  logic [2:0]                 fwd_mem_rd,
   input  logic [WORD_LEN-1:0]        fwd_mem_data,
   input  logic                       fwd_wb_en,
   input  logic [2:0]                 fwd_wb_rd,
   input  logic [WORD_LEN-1:0]        fwd_wb_data,
   input  logic                       stall,
   input  logic                       flush,
   output logic [WORD_LEN-1:0]        PR3_alu_result,
   output logic [WORD_LEN-1:0]        PR3_store_data,
   output logic [2:0]                 PR3_rd,
   output logic                       PR3_MEM_write,
   output logic                       PR3_MEM_read,
   output logic                       PR3_sel_RF_write_src_ALU,
   output logic                       PR3_sel_RF_write_src_MEM,
   output logic                       PR3_RF_write_en,
   output logic                       PR3_valid,
   output logic                       flag_C,
   output logic                       flag_Z
);

   logic [2:0]          rd, rs1;
   logic [7:0]          imm8;
   logic [2:0]          shamt;
   logic [WORD_LEN-1:0] op_a, op_st, op_b;
   alu_op_e             alu_op;
   logic                cin;
   logic [WORD_LEN-1:0] alu_res;
   logic                alu_c, alu_c_upd, alu_z_upd;
   logic                real_op;
   pr3_ctrl_t           ctrl_d, ctrl_q;
   logic [WORD_LEN-1:0] res_q, st_q;
   logic [2:0]          rd_q;
   logic                valid_q;
   logic                c_d, c_q, z_d, z_q;
   logic                unused_instr;

   assign rd    = PR2_instruction[RD_MSB:RD_LSB];
   assign rs1   = PR2_instruction[RS1_MSB:RS1_LSB];
   assign imm8  = PR2_instruction[IMM_MSB:IMM_LSB];
   assign shamt = PR2_instruction[SHAMT_MSB:SHAMT_LSB];
   assign unused_instr = ^PR2_instruction[INSTRUCTION_LEN-1:RD_MSB+1];

   // MEM is the younger producer, so it beats WB; R0 forwards like any register
   always_comb begin
      op_a = PR2_RF_out1;
      if (fwd_mem_en && fwd_mem_rd == rs1)     op_a = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_rd == rs1)  op_a = fwd_wb_data;
      op_st = PR2_RF_out2;
      if (fwd_mem_en && fwd_mem_rd == PR2_RF_r2)     op_st = fwd_mem_data;
      else if (fwd_wb_en && fwd_wb_rd == PR2_RF_r2)  op_st = fwd_wb_data;
   end

   always_comb begin
      op_b = '0;
      if (PR2_sel_ALU_src_const)             op_b = WORD_LEN'(imm8);
      else if (PR2_sel_ALU_src_shift_count)  op_b = WORD_LEN'(shamt);
      else if (PR2_sel_ALU_src_reg2)         op_b = op_st;
   end

   assign alu_op = alu_op_e'(PR2_ALU_op);
   assign cin    = PR2_sel_Cin_alu && is_carry_op(alu_op) && c_q;

   alu_core #(.WORD_LEN(WORD_LEN)) u_alu (
      .a         (op_a),
      .b         (op_b),
      .op        (alu_op),
      .cin       (cin),
      .c_in_flag (c_q),
      .result    (alu_res),
      .c_out     (alu_c),
      .c_upd     (alu_c_upd),
      .z_upd     (alu_z_upd)
   );

   assign real_op = PR2_RF_write_en | PR2_MEM_write | PR2_MEM_read;
   assign c_d     = (real_op && alu_c_upd) ? alu_c : c_q;
   assign z_d     = (real_op && alu_z_upd) ? (alu_res == '0) : z_q;
   assign ctrl_d  = '{mem_write: PR2_MEM_write, mem_read: PR2_MEM_read,
                      src_alu: PR2_sel_RF_write_src_ALU, src_mem: PR2_sel_RF_write_src_MEM,
                      rf_we: PR2_RF_write_en};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q   <= '0;
         st_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else if (flush) begin
         res_q   <= '0;
         st_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         res_q   <= alu_res;
         st_q    <= op_st;
         rd_q    <= rd;
         ctrl_q  <= ctrl_d;
         valid_q <= 1'b1;
         c_q     <= c_d;
         z_q     <= z_d;
      end
   end

   assign PR3_alu_result           = res_q;
   assign PR3_store_data           = st_q;
   assign PR3_rd                   = rd_q;
   assign PR3_MEM_write            = ctrl_q.mem_write;
   assign PR3_MEM_read             = ctrl_q.mem_read;
   assign PR3_sel_RF_write_src_ALU = ctrl_q.src_alu;
   assign PR3_sel_RF_write_src_MEM = ctrl_q.src_mem;
   assign PR3_RF_write_en          = ctrl_q.rf_we;
   assign PR3_valid                = valid_q;
   assign flag_C                   = c_q;
   assign flag_Z                   = z_q;

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Bench for ex_stage_exmem: directed scenarios plus random traffic against an arithmetic model.
module tb_ex_stage_exmem;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] PR2_instruction;
   logic [7:0]  PR2_RF_out1, PR2_RF_out2;
   logic [2:0]  PR2_RF_r2;
   logic [3:0]  PR2_ALU_op;
   logic        PR2_sel_ALU_src_reg2, PR2_sel_ALU_src_const, PR2_sel_ALU_src_shift_count;
   logic        PR2_sel_Cin_alu, PR2_MEM_write, PR2_MEM_read;
   logic        PR2_sel_RF_write_src_ALU, PR2_sel_RF_write_src_MEM, PR2_RF_write_en;
   logic        fwd_mem_en, fwd_wb_en;
   logic [2:0]  fwd_mem_rd, fwd_wb_rd;
   logic [7:0]  fwd_mem_data, fwd_wb_data;
   logic        stall, flush;
   logic [7:0]  PR3_alu_result, PR3_store_data;
   logic [2:0]  PR3_rd;
   logic        PR3_MEM_write, PR3_MEM_read, PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM;
   logic        PR3_RF_write_en, PR3_valid, flag_C, flag_Z;

   always #5 clk = ~clk;

   ex_stage_exmem dut (
      .clk(clk), .rst(rst),
      .PR2_instruction(PR2_instruction), .PR2_RF_out1(PR2_RF_out1), .PR2_RF_out2(PR2_RF_out2),
      .PR2_RF_r2(PR2_RF_r2), .PR2_ALU_op(PR2_ALU_op),
      .PR2_sel_ALU_src_reg2(PR2_sel_ALU_src_reg2), .PR2_sel_ALU_src_const(PR2_sel_ALU_src_const),
      .PR2_sel_ALU_src_shift_count(PR2_sel_ALU_src_shift_count), .PR2_sel_Cin_alu(PR2_sel_Cin_alu),
      .PR2_MEM_write(PR2_MEM_write), .PR2_MEM_read(PR2_MEM_read),
      .PR2_sel_RF_write_src_ALU(PR2_sel_RF_write_src_ALU),
      .PR2_sel_RF_write_src_MEM(PR2_sel_RF_write_src_MEM), .PR2_RF_write_en(PR2_RF_write_en),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .stall(stall), .flush(flush),
      .PR3_alu_result(PR3_alu_result), .PR3_store_data(PR3_store_data), .PR3_rd(PR3_rd),
      .PR3_MEM_write(PR3_MEM_write), .PR3_MEM_read(PR3_MEM_read),
      .PR3_sel_RF_write_src_ALU(PR3_sel_RF_write_src_ALU),
      .PR3_sel_RF_write_src_MEM(PR3_sel_RF_write_src_MEM),
      .PR3_RF_write_en(PR3_RF_write_en), .PR3_valid(PR3_valid),
      .flag_C(flag_C), .flag_Z(flag_Z)
   );

   typedef struct packed {
      logic [2:0] rd, rs1;
      logic [7:0] imm, out1, out2;
      logic [2:0] r2;
      logic [3:0] op;
      logic       reg2, cnst, shc, cin;
      logic       mw, mr, wa, wm, we;
      logic       fme;
      logic [2:0] fmrd;
      logic [7:0] fmd;
      logic       fwe;
      logic [2:0] fwrd;
      logic [7:0] fwd;
      logic       stall, flush;
   } stim_t;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [7:0] e_res, e_st;
   logic [2:0] e_rd;
   logic       e_mw, e_mr, e_wa, e_wm, e_we, e_v, m_C, m_Z;

   logic [24:0] dut_pr3;
   assign dut_pr3 = {PR3_alu_result, PR3_store_data, PR3_rd, PR3_MEM_write, PR3_MEM_read,
                     PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM, PR3_RF_write_en, PR3_valid};

   function automatic logic [24:0] exp_pr3();
      return {e_res, e_st, e_rd, e_mw, e_mr, e_wa, e_wm, e_we, e_v};
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic model_reset();
      {e_res, e_st, e_rd, e_mw, e_mr, e_wa, e_wm, e_we, e_v, m_C, m_Z} = '0;
   endtask

   task automatic drive(input stim_t s);
      PR2_instruction = {5'b0, s.rd, s.rs1, s.imm};
      PR2_RF_out1 = s.out1;  PR2_RF_out2 = s.out2;  PR2_RF_r2 = s.r2;  PR2_ALU_op = s.op;
      PR2_sel_ALU_src_reg2 = s.reg2;  PR2_sel_ALU_src_const = s.cnst;
      PR2_sel_ALU_src_shift_count = s.shc;  PR2_sel_Cin_alu = s.cin;
      PR2_MEM_write = s.mw;  PR2_MEM_read = s.mr;
      PR2_sel_RF_write_src_ALU = s.wa;  PR2_sel_RF_write_src_MEM = s.wm;  PR2_RF_write_en = s.we;
      fwd_mem_en = s.fme;  fwd_mem_rd = s.fmrd;  fwd_mem_data = s.fmd;
      fwd_wb_en = s.fwe;   fwd_wb_rd = s.fwrd;   fwd_wb_data = s.fwd;
      stall = s.stall;  flush = s.flush;
   endtask

   // Spec-level model of one clock edge.
   task automatic predict(input stim_t s);
      int a, st, b, t, res, n, cin;
      logic c;
      bit cu, zu;
      a = s.out1;
      if (s.fme && s.fmrd == s.rs1)      a = s.fmd;
      else if (s.fwe && s.fwrd == s.rs1) a = s.fwd;
      st = s.out2;
      if (s.fme && s.fmrd == s.r2)       st = s.fmd;
      else if (s.fwe && s.fwrd == s.r2)  st = s.fwd;
      b = s.cnst ? int'(s.imm) : s.shc ? int'(s.imm) % 8 : s.reg2 ? st : 0;
      cin = (s.cin && (s.op == 1 || s.op == 3)) ? int'(m_C) : 0;
      c = m_C; cu = 1; zu = 1; res = 0;
      n = b % 8;
      case (s.op)
         0, 1: begin t = a + b + cin; res = t % 256; c = (t > 255); end
         2, 3: begin t = a - b - cin; res = (t + 512) % 256; c = (t < 0); end
         4: begin res = a & b; cu = 0; end
         5: begin res = a | b; cu = 0; end
         6: begin res = a ^ b; cu = 0; end
         7: begin res = a & (255 - b); cu = 0; end
         8, 9, 10, 11: begin
            if (n == 0) begin res = a; cu = 0; end
            else if (s.op == 8)  begin res = (a << n) % 256; c = ((a >> (8 - n)) & 1) != 0; end
            else if (s.op == 9)  begin res = a >> n;         c = ((a >> (n - 1)) & 1) != 0; end
            else if (s.op == 10) begin res = ((a << n) | (a >> (8 - n))) % 256; c = ((a >> (8 - n)) & 1) != 0; end
            else                 begin res = ((a >> n) | (a << (8 - n))) % 256; c = ((a >> (n - 1)) & 1) != 0; end
         end
         default: begin res = b; cu = 0; zu = 0; end
      endcase
      if (s.flush) begin
         {e_res, e_st, e_rd, e_mw, e_mr, e_wa, e_wm, e_we, e_v} = '0;
      end else if (!s.stall) begin
         e_res = res[7:0]; e_st = st[7:0]; e_rd = s.rd;
         {e_mw, e_mr, e_wa, e_wm, e_we, e_v} = {s.mw, s.mr, s.wa, s.wm, s.we, 1'b1};
         if (s.we || s.mw || s.mr) begin
            if (cu) m_C = c;
            if (zu) m_Z = (res == 0);
         end
      end
   endtask

   task automatic cycle(input stim_t s);
      drive(s);
      predict(s);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (dut_pr3 !== 25'h0 || {flag_C, flag_Z} !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: got pr3=%h CZ=%b, want 0/00", dut_pr3, {flag_C, flag_Z});
      end
   endtask

   task automatic test_add_addc();
      stim_t s;
      s = idle();
      s.rs1 = 3'd1; s.out1 = 8'hF0; s.r2 = 3'd2; s.out2 = 8'h20; s.reg2 = 1; s.op = 4'd0;
      s.we = 1; s.wa = 1; s.rd = 3'd4;
      cycle(s);
      checks++;
      if ({PR3_alu_result, flag_C, flag_Z, PR3_valid} !== {8'h10, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add: got res=%h C=%b Z=%b v=%b, want 10 1 0 1", PR3_alu_result, flag_C, flag_Z, PR3_valid);
      end
      checks++;
      if (dut_pr3 !== exp_pr3()) begin
         errors++; $display("FAIL add_pr3: got %h want %h", dut_pr3, exp_pr3());
      end
      s.out1 = 8'h01; s.out2 = 8'h01; s.op = 4'd1; s.cin = 1;
      cycle(s);
      checks++;
      if (PR3_alu_result !== 8'h03) begin
         errors++; $display("FAIL addc: got %h want 03", PR3_alu_result);
      end
   endtask

   task automatic test_forwarding();
      stim_t s;
      s = idle();
      s.rs1 = 3'd3; s.out1 = 8'h99; s.r2 = 3'd3; s.out2 = 8'h77; s.cnst = 1; s.imm = 8'h0F;
      s.op = 4'd4; s.we = 1; s.wa = 1; s.rd = 3'd5;
      s.fme = 1; s.fmrd = 3'd3; s.fmd = 8'h55; s.fwe = 1; s.fwrd = 3'd3; s.fwd = 8'hAA;
      cycle(s);
      checks++;
      if ({PR3_alu_result, PR3_store_data} !== {8'h05, 8'h55}) begin
         errors++; $display("FAIL fwd_mem: got res=%h st=%h want 05 55", PR3_alu_result, PR3_store_data);
      end
      s.fme = 0;
      cycle(s);
      checks++;
      if ({PR3_alu_result, PR3_store_data} !== {8'h0A, 8'hAA}) begin
         errors++; $display("FAIL fwd_wb: got res=%h st=%h want 0a aa", PR3_alu_result, PR3_store_data);
      end
      s.fwe = 0; s.rs1 = 3'd0; s.fme = 1; s.fmrd = 3'd0;
      cycle(s);
      checks++;
      if (dut_pr3 !== exp_pr3()) begin
         errors++; $display("FAIL fwd_r0: got %h want %h", dut_pr3, exp_pr3());
      end
   endtask

   task automatic test_shifts();
      stim_t s;
      s = idle();
      s.out1 = 8'h81; s.shc = 1; s.imm = 8'h01; s.op = 4'd9; s.we = 1;
      cycle(s);
      checks++;
      if ({PR3_alu_result, flag_C} !== {8'h40, 1'b1}) begin
         errors++; $display("FAIL shr: got %h C=%b want 40 1", PR3_alu_result, flag_C);
      end
      s.shc = 0; s.cnst = 1; s.imm = 8'd9; s.op = 4'd10;
      cycle(s);
      checks++;
      if (PR3_alu_result !== 8'h03) begin
         errors++; $display("FAIL rol9: got %h want 03", PR3_alu_result);
      end
      s.out1 = 8'h05; s.imm = 8'h03; s.op = 4'd2;
      cycle(s);
      s.out1 = 8'h81; s.imm = 8'd8; s.op = 4'd8;
      cycle(s);
      checks++;
      if ({PR3_alu_result, flag_C} !== {8'h81, 1'b0}) begin
         errors++; $display("FAIL shl0: got %h C=%b want 81 0", PR3_alu_result, flag_C);
      end
      checks++;
      if ({dut_pr3, flag_C, flag_Z} !== {exp_pr3(), m_C, m_Z}) begin
         errors++; $display("FAIL shl0_model: got %h want %h", {dut_pr3, flag_C, flag_Z}, {exp_pr3(), m_C, m_Z});
      end
   endtask

   task automatic test_stall_flush();
      stim_t s;
      logic [26:0] held;
      s = idle();
      s.out1 = 8'h12; s.out2 = 8'h34; s.reg2 = 1; s.op = 4'd0; s.we = 1; s.mw = 1; s.rd = 3'd6;
      cycle(s);
      held = {exp_pr3(), m_C, m_Z};
      for (int i = 0; i < 3; i++) begin
         s.out1 = 8'($urandom); s.out2 = 8'($urandom); s.op = 4'($urandom_range(0, 11));
         s.rd = 3'($urandom); s.stall = 1;
         cycle(s);
         checks++;
         if ({dut_pr3, flag_C, flag_Z} !== held) begin
            errors++; $display("FAIL stall%0d: got %h want %h", i, {dut_pr3, flag_C, flag_Z}, held);
         end
      end
      s.flush = 1;
      cycle(s);
      checks++;
      if ({PR3_valid, PR3_RF_write_en, PR3_MEM_write, PR3_MEM_read} !== 4'b0000 ||
          {flag_C, flag_Z} !== held[1:0]) begin
         errors++;
         $display("FAIL flush_stall: got v/we/mw/mr=%b CZ=%b want 0000 %b",
                  {PR3_valid, PR3_RF_write_en, PR3_MEM_write, PR3_MEM_read}, {flag_C, flag_Z}, held[1:0]);
      end
   endtask

   task automatic test_sub_bubble();
      stim_t s;
      s = idle();
      s.out1 = 8'h05; s.out2 = 8'h05; s.reg2 = 1; s.op = 4'd2; s.we = 1;
      cycle(s);
      checks++;
      if ({PR3_alu_result, flag_Z, flag_C} !== {8'h00, 1'b1, 1'b0}) begin
         errors++; $display("FAIL sub_zero: got %h Z=%b C=%b want 00 1 0", PR3_alu_result, flag_Z, flag_C);
      end
      s = idle();
      s.out1 = 8'h01; s.cnst = 1; s.imm = 8'h01;
      cycle(s);
      checks++;
      if ({PR3_alu_result, PR3_valid, flag_Z} !== {8'h02, 1'b1, 1'b1}) begin
         errors++; $display("FAIL bubble_z: got res=%h v=%b Z=%b want 02 1 1", PR3_alu_result, PR3_valid, flag_Z);
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int i = 0; i < 400; i++) begin
         s = stim_t'({$urandom, $urandom, $urandom});
         s.stall = ($urandom_range(0, 7) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         cycle(s);
         checks++;
         if ({dut_pr3, flag_C, flag_Z} !== {exp_pr3(), m_C, m_Z}) begin
            errors++;
            $display("FAIL random%0d: op=%0d got %h want %h", i, s.op, {dut_pr3, flag_C, flag_Z}, {exp_pr3(), m_C, m_Z});
         end
      end
   endtask

   task automatic test_reset_midstall();
      stim_t s;
      s = idle();
      s.out1 = 8'hFF; s.out2 = 8'h01; s.reg2 = 1; s.op = 4'd0; s.we = 1; s.mr = 1; s.rd = 3'd7;
      cycle(s);
      s.stall = 1;
      cycle(s);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (dut_pr3 !== 25'h0 || {flag_C, flag_Z} !== 2'b00) begin
         errors++; $display("FAIL reset_async: got pr3=%h CZ=%b want 0/00", dut_pr3, {flag_C, flag_Z});
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      s.stall = 0; s.out1 = 8'h10;
      cycle(s);
      checks++;
      if ({dut_pr3, flag_C, flag_Z} !== {exp_pr3(), m_C, m_Z}) begin
         errors++; $display("FAIL reset_restart: got %h want %h", {dut_pr3, flag_C, flag_Z}, {exp_pr3(), m_C, m_Z});
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(idle());
      model_reset();
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      test_add_addc();
      test_forwarding();
      test_shifts();
      test_stall_flush();
      test_sub_bubble();
      test_random();
      test_reset_midstall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
